// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and the FIPS-197 forward S-box table.
// The table is also consumed by the datapath S-boxes.
package aes_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [BYTE_W-1:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte forward S-box: a purely combinational ROM lookup, no register stage.
module aes_sbox_byte
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_i,
    output logic [BYTE_W-1:0] byte_o
);

    assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/key_exp_sbox_server.sv
// Key-schedule SubWord responder: BYTES_PER_CYCLE shared S-boxes walk the word MS byte
// first while it rotates, so after 4/BYTES_PER_CYCLE steps the bytes are back in order.
module key_exp_sbox_server
    import aes_pkg::*;
#(
    parameter int WORD_W          = aes_pkg::WORD_W,
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] rnd_word_key_val,
    input  logic              rnd_word_key_val_vld,
    output logic [WORD_W-1:0] key_exp_sbox_data,
    output logic              key_exp_sbox_data_vld,
    output logic              sbox_busy,
    output logic              sbox_req_drop
);

    localparam int NSTEP = 4 / BYTES_PER_CYCLE;
    localparam int SUB_W = BYTE_W * BYTES_PER_CYCLE;
    localparam logic [1:0] CNT_LAST = 2'(NSTEP - 1);

    if (WORD_W != 32 || !(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4))
    begin : g_bad_param
        $error("key_exp_sbox_server: WORD_W must be 32 and BYTES_PER_CYCLE one of 1, 2, 4");
    end

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] work_q, work_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;
    logic              drop_q, drop_d;

    logic [SUB_W-1:0]  sub_bytes;
    logic [WORD_W-1:0] sub_word;
    logic [WORD_W-1:0] step_word;

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        aes_sbox_byte u_sbox (
            .byte_i (work_q[WORD_W-1-BYTE_W*g -: BYTE_W]),
            .byte_o (sub_bytes[SUB_W-1-BYTE_W*g -: BYTE_W])
        );
    end

    // Replace the top bytes, then rotate them to the bottom; a full-width rotate is identity.
    always_comb begin
        sub_word = work_q;
        sub_word[WORD_W-1 -: SUB_W] = sub_bytes;
        step_word = (sub_word << SUB_W) | (sub_word >> (WORD_W - SUB_W));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        drop_d  = drop_q;
        case (state_q)
            IDLE: begin
                if (rnd_word_key_val_vld) begin
                    work_d  = rnd_word_key_val;
                    cnt_d   = 2'd0;
                    state_d = SUB;
                end
            end
            SUB: begin
                work_d = step_word;
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == CNT_LAST) state_d = DONE;
                if (rnd_word_key_val_vld) drop_d = 1'b1;
            end
            DONE: begin
                data_d = work_q;
                vld_d  = 1'b1;
                if (rnd_word_key_val_vld) begin
                    work_d  = rnd_word_key_val;
                    cnt_d   = 2'd0;
                    state_d = SUB;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            work_q  <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            drop_q  <= drop_d;
        end
    end

    assign key_exp_sbox_data     = data_q;
    assign key_exp_sbox_data_vld = vld_q;
    assign sbox_busy             = (state_q == SUB);
    assign sbox_req_drop         = drop_q;

endmodule

// File: doc/key_exp_sbox_server.md
Name: key_exp_sbox_server

Overview:
- Responder side of the key-expansion S-box handshake.
- Accepts a 32-bit word request (rnd_word_key_val/_vld) from key_expansion, applies AES SubWord (FIPS-197 S-box per byte) and returns the result on key_exp_sbox_data/_vld.
- Area-optimised: a configurable number of byte S-boxes is time-shared over the 4 bytes of the word.
- Sits between key_expansion and nothing else; dedicated to the key schedule, separate from the datapath S-boxes.

Parameters:
- WORD_W, 32 (`WORD_DATA_WIDTH): request/response word width; only 32 supported.
- BYTES_PER_CYCLE, 1: S-box instances, and bytes substituted per cycle. Legal values 1, 2, 4. Any other value is a compile-time error.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rnd_word_key_val  input  32  word to substitute (byte3 = [31:24]).
- rnd_word_key_val_vld  input  1  single-cycle request strobe.
- key_exp_sbox_data  output  32  SubWord result; held stable until the next response.
- key_exp_sbox_data_vld  output  1  single-cycle response strobe.
- sbox_busy  output  1  high while a request is in flight (state SUB).
- sbox_req_drop  output  1  sticky: a request arrived while busy. Cleared only by reset.

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE.
  - key_exp_sbox_data=0, key_exp_sbox_data_vld=0, sbox_busy=0, sbox_req_drop=0.
  - Byte counter=0, work register=0.
- Reset mid-operation aborts the request: no response, no drop flag.
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - On vld=1: capture the word into the work register, counter=0, go to SUB.
- SUB:
  - Each cycle, substitute BYTES_PER_CYCLE bytes, MS byte first.
  - Work register rotates left by 8*BYTES_PER_CYCLE.
  - Counter increments. The transition to DONE occurs after NSTEP = 4/BYTES_PER_CYCLE cycles.
  - After NSTEP rotations the work register holds {S(b3),S(b2),S(b1),S(b0)} in original byte order.
- DONE (one cycle):
  - key_exp_sbox_data <= work register; key_exp_sbox_data_vld=1 for exactly this cycle.
  - If vld=1 in DONE, the new request is accepted (captured, go to SUB). Otherwise go to IDLE.
- Latency: request sampled at edge N, response vld visible in the cycle after edge N+NSTEP+1.
  - BYTES_PER_CYCLE=1: 5 cycles.
  - BYTES_PER_CYCLE=2: 3 cycles.
  - BYTES_PER_CYCLE=4: 2 cycles.
- Minimum request spacing is NSTEP+1 cycles (back-to-back through DONE).
- Request while in SUB:
  - Ignored; the in-flight computation is unaffected.
  - sbox_req_drop set on the next edge.
- key_exp_sbox_data changes only in DONE; otherwise it holds the last result (0 after reset).
- No X propagation: rnd_word_key_val is ignored unless vld=1.
- The S-box is a pure combinational 256-entry ROM. No registered stage inside the sub-module.

Decomposition:
- Shared package aes_pkg:
  - WORD_W and BYTE_W constants.
  - Typedef state enum (IDLE/SUB/DONE), 2 bits.
  - FIPS-197 forward S-box constant array [256][8], also reused by datapath S-boxes.
- Sub-module aes_sbox_byte: 8-bit in, 8-bit out, combinational lookup from the package table. Instantiated BYTES_PER_CYCLE times.

Test Plan:
- Reset, then req 0x00000000 with BYTES_PER_CYCLE=1 -> vld pulse 5 cycles later, data 0x63636363, busy high for 4 cycles.
- Req 0xCF4F3C09 (FIPS-197 RotWord(w3)) -> data 0x8A84EB01. Repeat at BYTES_PER_CYCLE=2 (latency 3) and 4 (latency 2): identical data.
- Back-to-back: req 0x01FF5300 then req 0x00000000 asserted exactly in the DONE cycle -> responses 0x7C16ED63, then 0x63636363 NSTEP+1 cycles later; sbox_req_drop stays 0.
- Req 0xCF4F3C09, second req 0x12345678 two cycles later -> response 0x8A84EB01 only; sbox_req_drop=1 and stays 1 until reset.
- Assert reset during SUB -> all outputs 0 asynchronously, no vld pulse after release. Then req 0xFFFFFFFF -> 0x16161616.
- Idle with vld=0 and random data toggling -> no vld, data unchanged from last response.
